urv_writeback: RTL and testbench

URV_WRITEBACK -- requirements
Module: urv_writeback

---
 rtl/urv_writeback_pkg.sv | 31 +++
 rtl/urv_load_align.sv | 36 +++
 rtl/urv_writeback.sv | 114 +++++++++++
 tb/tb_urv_writeback.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/urv_writeback_pkg.sv
// rtl/urv_writeback_pkg.sv - shared encodings and types for the writeback stage
package urv_writeback_pkg;

    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_MUL  = 2'd1;
    localparam logic [1:0] SRC_LOAD = 2'd2;

    localparam logic [2:0] FUN_LB  = 3'b000;
    localparam logic [2:0] FUN_LH  = 3'b001;
    localparam logic [2:0] FUN_LW  = 3'b010;
    localparam logic [2:0] FUN_LBU = 3'b100;
    localparam logic [2:0] FUN_LHU = 3'b101;

    localparam int TMO_W = 10;

    typedef enum logic {
        W_IDLE      = 1'b0,
        W_LOAD_WAIT = 1'b1
    } w_state_e;

    typedef struct packed {
        logic        valid;
        logic        rd_write;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [31:0] value;
        logic [2:0]  fun;
        logic [1:0]  addr;
    } w_reg_t;

endpackage

// File: rtl/urv_load_align.sv
// rtl/urv_load_align.sv - combinational load data extraction and extension
module urv_load_align
    import urv_writeback_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  fun_i,
    input  logic [1:0]  addr_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (addr_i)
            2'd0:    byte_sel = data_i[7:0];
            2'd1:    byte_sel = data_i[15:8];
            2'd2:    byte_sel = data_i[23:16];
            default: byte_sel = data_i[31:24];
        endcase
        // misaligned halves fall back to the half selected by addr[1]
        half_sel = addr_i[1] ? data_i[31:16] : data_i[15:0];

        data_o = data_i;
        case (fun_i)
            FUN_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            FUN_LH:  data_o = {{16{half_sel[15]}}, half_sel};
            FUN_LW:  data_o = data_i;
            FUN_LBU: data_o = {24'h0, byte_sel};
            FUN_LHU: data_o = {16'h0, half_sel};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/urv_writeback.sv
// rtl/urv_writeback.sv - W stage: result select, load wait with timeout, regfile write
module urv_writeback
    import urv_writeback_pkg::*;
#(
    parameter int g_load_timeout = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        x_valid_i,
    input  logic        x_rd_write_i,
    input  logic [4:0]  x_rd_i,
    input  logic [1:0]  x_rd_source_i,
    input  logic [31:0] x_rd_value_i,
    input  logic [2:0]  x_fun_i,
    input  logic [1:0]  x_dm_addr_i,
    input  logic [31:0] w_mul_result_i,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    output logic        w_stall_req_o,
    output logic        rf_write_o,
    output logic [4:0]  rf_index_o,
    output logic [31:0] rf_data_o,
    output logic        w_load_timeout_o
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(g_load_timeout - 1);

    w_reg_t           w_q, w_d;
    w_state_e         state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;

    logic [31:0] load_data;
    logic        w_is_load;
    logic        load_done;
    logic        load_tmo;
    logic        data_ready;
    logic        wr_en;

    urv_load_align u_align (
        .data_i (dm_data_l_i),
        .fun_i  (w_q.fun),
        .addr_i (w_q.addr),
        .data_o (load_data)
    );

    always_comb begin
        w_is_load  = w_q.valid && (w_q.src == SRC_LOAD);
        load_done  = w_is_load && dm_load_done_i;
        load_tmo   = w_is_load && !dm_load_done_i &&
                     (state_q == W_LOAD_WAIT) && (cnt_q == TMO_LAST);
        // the timeout cycle releases the stall so the pipeline drains
        w_stall_req_o = w_is_load && !dm_load_done_i && !load_tmo;
        data_ready = !w_is_load || load_done || load_tmo;
        wr_en      = w_q.valid && w_q.rd_write && (w_q.rd != 5'd0) && data_ready;

        rf_write_o       = wr_en;
        rf_index_o       = wr_en ? w_q.rd : 5'd0;
        w_load_timeout_o = load_tmo;
        rf_data_o        = 32'h0;
        if (wr_en) begin
            case (w_q.src)
                SRC_MUL:  rf_data_o = w_mul_result_i;
                SRC_LOAD: rf_data_o = load_tmo ? 32'h0 : load_data;
                default:  rf_data_o = w_q.value;
            endcase
        end
    end

    always_comb begin
        w_d = w_q;
        if (!w_stall_req_o) begin
            w_d.valid    = x_valid_i;
            w_d.rd_write = x_rd_write_i;
            w_d.rd       = x_rd_i;
            w_d.src      = x_rd_source_i;
            w_d.value    = x_rd_value_i;
            w_d.fun      = x_fun_i;
            w_d.addr     = x_dm_addr_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            W_IDLE: begin
                if (w_stall_req_o) begin
                    state_d = W_LOAD_WAIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (!w_stall_req_o) begin
                    state_d = W_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            w_q     <= '0;
            state_q <= W_IDLE;
            cnt_q   <= '0;
        end else begin
            w_q     <= w_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_urv_writeback.sv
// tb/tb_urv_writeback.sv - directed self-checking bench for urv_writeback
module tb_urv_writeback;
    import urv_writeback_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        x_valid;
    logic        x_rd_write;
    logic [4:0]  x_rd;
    logic [1:0]  x_src;
    logic [31:0] x_value;
    logic [2:0]  x_fun;
    logic [1:0]  x_addr;
    logic [31:0] mul_result;
    logic [31:0] dm_data;
    logic        dm_done;
    logic        stall;
    logic        rf_write;
    logic [4:0]  rf_index;
    logic [31:0] rf_data;
    logic        tmo;

    int n_checks = 0;
    int n_errors = 0;

    urv_writeback #(.g_load_timeout(8)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .x_valid_i        (x_valid),
        .x_rd_write_i     (x_rd_write),
        .x_rd_i           (x_rd),
        .x_rd_source_i    (x_src),
        .x_rd_value_i     (x_value),
        .x_fun_i          (x_fun),
        .x_dm_addr_i      (x_addr),
        .w_mul_result_i   (mul_result),
        .dm_data_l_i      (dm_data),
        .dm_load_done_i   (dm_done),
        .w_stall_req_o    (stall),
        .rf_write_o       (rf_write),
        .rf_index_o       (rf_index),
        .rf_data_o        (rf_data),
        .w_load_timeout_o (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input logic v, input logic w, input logic [4:0] rd, input logic [1:0] src,
                         input logic [31:0] val, input logic [2:0] fun, input logic [1:0] addr);
        x_valid    = v;
        x_rd_write = w;
        x_rd       = rd;
        x_src      = src;
        x_value    = val;
        x_fun      = fun;
        x_addr     = addr;
    endtask

    task automatic set_idle();
        set_x(1'b0, 1'b0, 5'd0, SRC_ALU, 32'h0, 3'd0, 2'd0);
    endtask

    task automatic check_write(input string tag, input logic [4:0] rd, input logic [31:0] data);
        check({tag, "_we"}, {31'h0, rf_write}, 32'h1);
        check({tag, "_idx"}, {27'h0, rf_index}, {27'h0, rd});
        check({tag, "_data"}, rf_data, data);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_we"}, {31'h0, rf_write}, 32'h0);
        check({tag, "_idx"}, {27'h0, rf_index}, 32'h0);
        check({tag, "_data"}, rf_data, 32'h0);
    endtask

    // load issued from X, done raised after `waits` stalled cycles
    task automatic run_load(input string tag, input logic [2:0] fun, input logic [1:0] addr,
                            input logic [4:0] rd, input int waits, input logic [31:0] exp);
        set_x(1'b1, 1'b1, rd, SRC_LOAD, 32'h0, fun, addr);
        dm_done = 1'b0;
        tick();
        set_idle();
        for (int i = 0; i < waits; i++) begin
            #1;
            check({tag, "_stall"}, {31'h0, stall}, 32'h1);
            tick();
        end
        dm_done = 1'b1;
        #1;
        check({tag, "_nostall"}, {31'h0, stall}, 32'h0);
        check_write(tag, rd, exp);
        tick();
        dm_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        mul_result = 32'h0000_0F00;
        dm_data    = 32'h80FF_7F01;
        dm_done    = 1'b0;
        set_idle();
        tick();
        #1;
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_tmo", {31'h0, tmo}, 32'h0);
        check_quiet("rst");
        rst_n = 1'b1;

        // ALU write
        set_x(1'b1, 1'b1, 5'd5, SRC_ALU, 32'h1234_5678, 3'd0, 2'd0);
        tick();
        set_idle();
        #1;
        check("alu_stall", {31'h0, stall}, 32'h0);
        check_write("alu", 5'd5, 32'h1234_5678);

        // write to x0 suppressed
        set_x(1'b1, 1'b1, 5'd0, SRC_ALU, 32'hDEAD_BEEF, 3'd0, 2'd0);
        tick();
        set_idle();
        #1;
        check_quiet("x0");

        // reserved source behaves as ALU
        set_x(1'b1, 1'b1, 5'd9, 2'd3, 32'hAABB_CCDD, 3'd0, 2'd0);
        tick();
        set_idle();
        #1;
        check_write("rsvd_src", 5'd9, 32'hAABB_CCDD);

        // invalid instruction with rd_write must not write
        set_x(1'b0, 1'b1, 5'd6, SRC_ALU, 32'h1111_1111, 3'd0, 2'd0);
        tick();
        #1;
        check_quiet("invalid");

        // MUL direct
        set_x(1'b1, 1'b1, 5'd4, SRC_MUL, 32'h0, 3'd0, 2'd0);
        tick();
        set_idle();
        #1;
        check_write("mul", 5'd4, 32'h0000_0F00);

        // done strobe with nothing in W is ignored
        tick();
        dm_done = 1'b1;
        #1;
        check_quiet("done_idle");
        check("done_idle_stall", {31'h0, stall}, 32'h0);
        dm_done = 1'b0;

        // load alignment variants
        run_load("lb", FUN_LB, 2'b11, 5'd10, 4, 32'hFFFF_FF80);
        run_load("lbu", FUN_LBU, 2'b11, 5'd10, 4, 32'h0000_0080);
        run_load("lh_mis", FUN_LH, 2'b01, 5'd14, 1, 32'h0000_7F01);
        run_load("lh_hi", FUN_LH, 2'b10, 5'd15, 2, 32'hFFFF_80FF);
        run_load("lhu_hi", FUN_LHU, 2'b10, 5'd16, 0, 32'h0000_80FF);
        run_load("lw", FUN_LW, 2'b01, 5'd17, 0, 32'h80FF_7F01);
        run_load("lb0", FUN_LB, 2'b00, 5'd18, 0, 32'h0000_0001);
        run_load("rsvd_fun", 3'b011, 2'b10, 5'd19, 1, 32'h80FF_7F01);

        // MUL held in X behind a 3-cycle load stall
        set_x(1'b1, 1'b1, 5'd11, SRC_LOAD, 32'h0, FUN_LW, 2'b00);
        dm_done = 1'b0;
        tick();
        set_x(1'b1, 1'b1, 5'd7, SRC_MUL, 32'h0, 3'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mulst_stall", {31'h0, stall}, 32'h1);
            check("mulst_we", {31'h0, rf_write}, 32'h0);
            tick();
        end
        dm_done = 1'b1;
        #1;
        check_write("mulst_ld", 5'd11, 32'h80FF_7F01);
        tick();
        dm_done = 1'b0;
        set_idle();
        #1;
        check_write("mulst_mul", 5'd7, 32'h0000_0F00);

        // timeout after 8 wait cycles
        set_x(1'b1, 1'b1, 5'd12, SRC_LOAD, 32'h0, FUN_LW, 2'b00);
        tick();
        set_idle();
        for (int i = 0; i < 8; i++) begin
            #1;
            check("tmo_stall", {31'h0, stall}, 32'h1);
            check("tmo_early", {31'h0, tmo}, 32'h0);
            tick();
        end
        #1;
        check("tmo_pulse", {31'h0, tmo}, 32'h1);
        check("tmo_release", {31'h0, stall}, 32'h0);
        check_write("tmo", 5'd12, 32'h0);
        tick();
        #1;
        check("tmo_once", {31'h0, tmo}, 32'h0);
        check_quiet("tmo_after");

        // reset while waiting abandons the load
        set_x(1'b1, 1'b1, 5'd13, SRC_LOAD, 32'h0, FUN_LW, 2'b00);
        tick();
        set_idle();
        tick();
        tick();
        #1;
        check("rstw_stall", {31'h0, stall}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rstw_stall0", {31'h0, stall}, 32'h0);
        check("rstw_tmo", {31'h0, tmo}, 32'h0);
        check_quiet("rstw");
        tick();
        rst_n = 1'b1;
        dm_done = 1'b1;
        #1;
        check_quiet("rstw_done");
        tick();
        dm_done = 1'b0;
        #1;
        check_quiet("rstw_done2");

        // capture works right after reset release
        set_x(1'b1, 1'b1, 5'd3, SRC_ALU, 32'h0000_0001, 3'd0, 2'd0);
        tick();
        set_idle();
        #1;
        check_write("post_rst", 5'd3, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
